// File: rtl/cpu_pkg.sv
// Shared field widths, FSM encoding and the instruction word layout.
package cpu_pkg;
  localparam int OP_W   = 3;
  localparam int REG_W  = 4;
  localparam int IMM_W  = 7;
  localparam int R3_MSB = 6;
  localparam int R3_LSB = 3;

  typedef enum logic {IDLE, HOLD} state_t;

  // Switch fields as one word so they synchronize and latch together.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] destino;
    logic [REG_W-1:0] r2;
    logic [IMM_W-1:0] inp;
  } instr_t;
endpackage

// File: rtl/key_debounce.sv
// Synchronizer + stable-level counter for one active-low push-button.
// press/rel are registered one-cycle strobes on debounced transitions.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level;
  logic                   db;     // debounced level, 1 = released
  logic [CW-1:0]          cnt;

  assign level = sync[SYNC_STAGES-1];

  // Shift in the raw key; flip the debounced level after a full run of mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '1;
      db    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], key_n};
      press <= 1'b0;
      rel   <= 1'b0;
      if (level != db) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          db    <= level;
          cnt   <= '0;
          press <= ~level;
          rel   <= level;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/instr_capture.sv
// Turns board keys/switches into a latched instruction plus exec/send strobes.
module instr_capture
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_exec_n,
  input  logic             key_send_n,
  input  logic [OP_W-1:0]  op_sw,
  input  logic [REG_W-1:0] destino_sw,
  input  logic [REG_W-1:0] r2_sw,
  input  logic [IMM_W-1:0] inp_sw,
  output logic [OP_W-1:0]  op,
  output logic [REG_W-1:0] destino,
  output logic [REG_W-1:0] r2,
  output logic [IMM_W-1:0] inp,
  output logic             exec_pulse,
  output logic             send_pulse,
  output logic             instr_valid,
  output logic             busy
);
  instr_t                   sw_now, cur;
  instr_t [SYNC_STAGES-1:0] sw_sync;
  state_t                   state, state_d;
  logic                     exec_press, exec_rel, send_press, send_rel_unused;
  logic                     capture, send_fire;

  assign sw_now = {op_sw, destino_sw, r2_sw, inp_sw};

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_exec (
    .clk(clk), .rst(rst), .key_n(key_exec_n), .press(exec_press), .rel(exec_rel));

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_send (
    .clk(clk), .rst(rst), .key_n(key_send_n), .press(send_press), .rel(send_rel_unused));

  // Switch synchronizer chain; all fields move together.
  always_ff @(posedge clk) begin
    if (rst) sw_sync <= '0;
    else     sw_sync <= {sw_sync[SYNC_STAGES-2:0], sw_now};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state; exec press has priority over a same-cycle send press.
  always_comb begin
    state_d   = state;
    capture   = 1'b0;
    send_fire = 1'b0;
    case (state)
      IDLE: begin
        if (exec_press) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (send_press && instr_valid) begin
          send_fire = 1'b1;
        end
      end
      HOLD:    if (exec_rel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered strobes and the latched instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= '0;
      exec_pulse  <= 1'b0;
      send_pulse  <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      exec_pulse <= capture;
      send_pulse <= send_fire;
      if (capture) begin
        cur         <= sw_sync[SYNC_STAGES-1];
        instr_valid <= 1'b1;
      end
    end
  end

  assign op      = cur.op;
  assign destino = cur.destino;
  assign r2      = cur.r2;
  assign inp     = cur.inp;
  assign busy    = (state == HOLD);
endmodule

// File: doc/instr_capture.md
Name: instr_capture

Overview:
- Front-end stage that turns the raw board switches and push-buttons into a clean, registered instruction for the CPU datapath.
- Synchronizes and debounces the execute key (key3) and send key (key2).
- Latches op/destino/R2/inp switch fields atomically on an execute press.
- Emits single-cycle execute and send strobes consumed by the register/ALU stage and the LCD stage.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); benches use 4
SYNC_STAGES, 2, flip-flop synchronizer depth on every key and switch input (minimum 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_exec_n  in  1  execute push-button, active-low (key3)
key_send_n  in  1  send-to-LCD push-button, active-low (key2)
op_sw  in  3  opcode switches
destino_sw  in  4  destination register switches
r2_sw  in  4  source register switches
inp_sw  in  7  immediate / R3 switches (R3 = inp[6:3])
op  out  3  latched opcode
destino  out  4  latched destination address
r2  out  4  latched source address
inp  out  7  latched immediate field
exec_pulse  out  1  one-cycle strobe: new instruction valid this cycle
send_pulse  out  1  one-cycle strobe: display latched result
instr_valid  out  1  high once any instruction has been captured since reset
busy  out  1  high from capture until execute key release is accepted

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0; synchronizers cleared to released (1) for keys, 0 for switches; debounce counters 0; debounced key state = released; FSM -> IDLE.
- Synchronization: each key and switch bit passes SYNC_STAGES flops before any use.
- Debounce, per key:
  - Counter increments each cycle the synchronized level differs from the debounced state.
  - The counter clears on any cycle where the levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - A press is the debounced released->pressed transition; a release is the reverse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Latency: counting the first edge that samples key_exec_n=0 as edge 1 (SYNC_STAGES=2), the debounced state flips at edge DEBOUNCE_CYCLES+2 and exec_pulse is high for exactly the cycle after edge DEBOUNCE_CYCLES+3. The same latency applies to send_pulse.
- FSM states:
  - IDLE:
    - Exec press -> latch synchronized switches into op/destino/r2/inp, assert exec_pulse (registered, next cycle), set instr_valid, -> HOLD.
    - Send press with instr_valid=1 -> assert send_pulse.
    - Send press with instr_valid=0 -> ignore the press.
  - HOLD:
    - busy=1; switch changes do not affect outputs.
    - Further exec presses cannot occur until a release is accepted; send presses are ignored in HOLD.
    - Exec release -> IDLE, busy=0 on the following cycle.
- Simultaneous exec and send press in the same cycle: exec wins; that send press is dropped, and the user must release and press again.
- Latched outputs hold until the next capture; instr_valid clears only on reset.
- exec_pulse and send_pulse are never high in the same cycle and never high for more than 1 cycle per press.
- Reset mid-operation: immediate return to the reset state. A key still held when rst deasserts is treated as a new press after full debounce latency.

Decomposition:
- Shared package cpu_pkg:
  - OP_W=3, REG_W=4, IMM_W=7, R3_MSB=6, R3_LSB=3.
  - FSM state enum {IDLE, HOLD}.
- Sub-module key_debounce (synchronizer + counter + press/release strobes), parameterized by DEBOUNCE_CYCLES and SYNC_STAGES, instantiated once per key.

Test Plan:
- Reset: with rst=1 for 3 cycles -> all outputs 0, busy=0, instr_valid=0.
- Capture (DEBOUNCE_CYCLES=4):
  - Stimulus: op_sw=3'b010, destino_sw=4'd5, r2_sw=4'd3, inp_sw=7'h2A, key_exec_n low from edge 1 for 20 cycles.
  - Response: exec_pulse high one cycle after edge 7; outputs 010/5/3/2A; instr_valid=1; busy=1 until release is accepted, then 0.
- Glitch: key_exec_n low for 3 cycles then high -> no exec_pulse, outputs unchanged, busy stays 0.
- Send gating:
  - send press before any capture -> send_pulse never asserts.
  - After a capture, a send press -> send_pulse high exactly 1 cycle, DEBOUNCE_CYCLES+3 edges after the first low sample.
- Priority/hold:
  - Both keys pressed on the same edge -> exec_pulse only.
  - Switches changed to op=3'b111 while busy -> op stays 010.
- Reset mid-hold: rst pulsed while key_exec_n held low -> outputs 0. After rst deasserts, exec_pulse follows DEBOUNCE_CYCLES+3 edges later with the current switch values.
